// File: rtl/smadd_arb_pkg.sv
// Shared types and widths for the two-requester sign-magnitude adder arbiter.
package smadd_arb_pkg;

    localparam int SM_W  = 4;
    localparam int MAG_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/smadd_arb_if.sv
// Request/response bundle between two requesters, one consumer and the arbiter.
interface smadd_arb_if;
    import smadd_arb_pkg::*;

    logic            req0_valid;
    logic            req1_valid;
    logic            req0_ready;
    logic            req1_ready;
    logic [SM_W-1:0] req0_a;
    logic [SM_W-1:0] req0_b;
    logic [SM_W-1:0] req1_a;
    logic [SM_W-1:0] req1_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [SM_W-1:0] rsp_y;
    logic            rsp_id;
    logic            rsp_ovf;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_y, rsp_id, rsp_ovf
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_y, rsp_id, rsp_ovf
    );

endinterface

// File: rtl/smadd_arb_smadd.sv
// Raw sign-magnitude adder: returns the result sign and an unsaturated magnitude with carry.
module smadd
    import smadd_arb_pkg::*;
(
    input  logic [SM_W-1:0]  i_a,
    input  logic [SM_W-1:0]  i_b,
    output logic             o_sign,
    output logic [MAG_W:0]   o_mag
);

    logic [MAG_W-1:0] w_magA;
    logic [MAG_W-1:0] w_magB;

    assign w_magA = i_a[MAG_W-1:0];
    assign w_magB = i_b[MAG_W-1:0];

    // Unlike signs subtract the smaller magnitude and take the sign of the larger one.
    always_comb begin
        o_sign = 1'b0;
        o_mag  = '0;
        if (i_a[SM_W-1] == i_b[SM_W-1]) begin
            o_sign = i_a[SM_W-1];
            o_mag  = {1'b0, w_magA} + {1'b0, w_magB};
        end else if (w_magA >= w_magB) begin
            o_sign = i_a[SM_W-1];
            o_mag  = {1'b0, w_magA - w_magB};
        end else begin
            o_sign = i_b[SM_W-1];
            o_mag  = {1'b0, w_magB - w_magA};
        end
    end

endmodule

// File: rtl/smadd_arb.sv
// Round-robin arbiter sharing one sign-magnitude adder between two requesters,
// with saturation, zero normalisation and a completed-response counter.
module smadd_arb
    import smadd_arb_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic              clk,
    input  logic              reset,
    smadd_arb_if.slave        bus,
    output logic [CNT_W-1:0]  op_count
);

    state_t           r_state;
    state_t           w_nextState;
    logic             r_ptr;
    logic [SM_W-1:0]  r_a;
    logic [SM_W-1:0]  r_b;
    logic             r_id;
    logic [SM_W-1:0]  r_rspY;
    logic             r_rspId;
    logic             r_rspOvf;
    logic [CNT_W-1:0] r_opCount;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_sign;
    logic [MAG_W:0]   w_mag;
    logic             w_ovf;
    logic [SM_W-1:0]  w_y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Grants are gated by reset so ready stays low while reset is held.
    always_comb begin
        w_nextState = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!reset) begin
                    if (bus.req0_valid && (!bus.req1_valid || !r_ptr)) begin
                        w_grant0 = 1'b1;
                    end else if (bus.req1_valid) begin
                        w_grant1 = 1'b1;
                    end
                    if (w_grant0 || w_grant1) begin
                        w_nextState = CALC;
                    end
                end
            end
            CALC: begin
                w_nextState = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    smadd u_smadd (
        .i_a    (r_a),
        .i_b    (r_b),
        .o_sign (w_sign),
        .o_mag  (w_mag)
    );

    // A zero magnitude always reports as +0, including a -0 operand pair.
    always_comb begin
        w_ovf = (r_a[SM_W-1] == r_b[SM_W-1]) && (w_mag > {1'b0, {MAG_W{1'b1}}});
        if (w_ovf) begin
            w_y = {w_sign, {MAG_W{1'b1}}};
        end else if (w_mag[MAG_W-1:0] == '0) begin
            w_y = '0;
        end else begin
            w_y = {w_sign, w_mag[MAG_W-1:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_id      <= 1'b0;
            r_rspY    <= '0;
            r_rspId   <= 1'b0;
            r_rspOvf  <= 1'b0;
            r_opCount <= '0;
        end else begin
            if (w_grant0 || w_grant1) begin
                r_a   <= w_grant1 ? bus.req1_a : bus.req0_a;
                r_b   <= w_grant1 ? bus.req1_b : bus.req0_b;
                r_id  <= w_grant1;
                r_ptr <= ~w_grant1;
            end
            if (r_state == CALC) begin
                r_rspY   <= w_y;
                r_rspId  <= r_id;
                r_rspOvf <= w_ovf;
            end
            if ((r_state == RESP) && bus.rsp_ready) begin
                r_opCount <= r_opCount + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.rsp_valid  = (r_state == RESP);
    assign bus.rsp_y      = r_rspY;
    assign bus.rsp_id     = r_rspId;
    assign bus.rsp_ovf    = r_rspOvf;
    assign op_count       = r_opCount;

endmodule

// File: tb/tb_smadd_arb.sv
// Scoreboard bench for smadd_arb: directed requests push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_smadd_arb;
    import smadd_arb_pkg::*;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [CNT_W-1:0] op_count;

    smadd_arb_if bus();

    smadd_arb #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [3:0] y;
        logic       id;
        logic       ovf;
    } exp_t;

    exp_t expQ[$];
    int   checks    = 0;
    int   failures  = 0;
    int   expCount  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_rsp: got y=%0h id=%0h with empty scoreboard", bus.rsp_y, bus.rsp_id);
            end else begin
                e = expQ.pop_front();
                checkOutput("rsp_y", 32'(bus.rsp_y), 32'(e.y));
                checkOutput("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                checkOutput("rsp_ovf", 32'(bus.rsp_ovf), 32'(e.ovf));
                checkOutput("op_count_at_accept", 32'(op_count), 32'(expCount));
                expCount = (expCount + 1) % (1 << CNT_W);
            end
        end
    end

    // Issue one request from a single requester, scramble its inputs after
    // acceptance, and verify the response appears two cycles after the grant cycle.
    task automatic applyStimulus(input bit id, input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] y, input logic ovf);
        int  grantCyc;
        bit  seen;
        expQ.push_back(exp_t'{y, id, ovf});
        if (id == 1'b0) begin
            bus.req0_valid = 1'b1;
            bus.req0_a     = a;
            bus.req0_b     = b;
        end else begin
            bus.req1_valid = 1'b1;
            bus.req1_a     = a;
            bus.req1_b     = b;
        end
        seen     = 1'b0;
        grantCyc = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                seen     = 1'b1;
                grantCyc = cyc;
            end
        end
        checkOutput("grant_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #2;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a     = a ^ 4'b0101;
        bus.req0_b     = b ^ 4'b0110;
        bus.req1_a     = a ^ 4'b0101;
        bus.req1_b     = b ^ 4'b0110;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        checkOutput("rsp_latency", seen ? 32'(cyc - grantCyc) : 32'hFFFF_FFFF, 32'd2);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_a = 4'b0001; bus.req0_b = 4'b0001;
        bus.req1_a = 4'b0001; bus.req1_b = 4'b0001;
        bus.rsp_ready = 1'b1;
        reset = 1'b1;

        // Reset state with both requesters asking
        repeat (2) @(negedge clk);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_op_count", 32'(op_count), 32'd0);
        checkOutput("reset_req0_ready", 32'(bus.req0_ready), 32'd0);
        checkOutput("reset_req1_ready", 32'(bus.req1_ready), 32'd0);
        checkOutput("reset_rsp_y", 32'(bus.rsp_y), 32'd0);
        @(posedge clk);
        #2;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset = 1'b0;

        // Basic add, saturation, zero normalisation
        applyStimulus(1'b0, 4'b0011, 4'b1101, 4'b1010, 1'b0);
        @(posedge clk); #2;
        checkOutput("op_count_after_first", 32'(op_count), 32'd1);
        applyStimulus(1'b1, 4'b0101, 4'b0100, 4'b0111, 1'b1);
        @(posedge clk); #2;
        applyStimulus(1'b1, 4'b1110, 4'b1011, 4'b1111, 1'b1);
        @(posedge clk); #2;
        applyStimulus(1'b0, 4'b1011, 4'b0011, 4'b0000, 1'b0);
        @(posedge clk); #2;
        applyStimulus(1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b0);
        @(posedge clk); #2;
        applyStimulus(1'b1, 4'b1111, 4'b0111, 4'b0000, 1'b0);
        @(posedge clk); #2;
        applyStimulus(1'b1, 4'b1001, 4'b0110, 4'b0101, 1'b0);
        @(posedge clk); #2;
        checkOutput("op_count_after_seven", 32'(op_count), 32'd7);

        // Consumer stall in RESP with both requesters asking
        bus.rsp_ready = 1'b0;
        applyStimulus(1'b0, 4'b0010, 4'b1110, 4'b1100, 1'b0);
        @(posedge clk); #2;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stall_valid_%0d", i), 32'(bus.rsp_valid), 32'd1);
            checkOutput($sformatf("stall_y_%0d", i), 32'(bus.rsp_y), 32'hC);
            checkOutput($sformatf("stall_ready0_%0d", i), 32'(bus.req0_ready), 32'd0);
            checkOutput($sformatf("stall_ready1_%0d", i), 32'(bus.req1_ready), 32'd0);
            checkOutput($sformatf("stall_count_%0d", i), 32'(op_count), 32'd7);
        end
        @(posedge clk); #2;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        @(posedge clk); #2;
        checkOutput("op_count_after_stall", 32'(op_count), 32'd8);
        checkOutput("rsp_valid_after_stall", 32'(bus.rsp_valid), 32'd0);

        // Reset while an operation is in CALC; pointer would otherwise favour req1
        bus.req0_valid = 1'b1;
        bus.req0_a = 4'b0001;
        bus.req0_b = 4'b0001;
        @(negedge clk);
        checkOutput("pre_reset_grant0", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #2;
        reset    = 1'b1;
        expCount = 0;
        @(negedge clk);
        checkOutput("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("midreset_op_count", 32'(op_count), 32'd0);
        checkOutput("midreset_req0_ready", 32'(bus.req0_ready), 32'd0);
        checkOutput("midreset_rsp_y", 32'(bus.rsp_y), 32'd0);
        @(posedge clk); #2;
        bus.req0_valid = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post_reset_no_rsp_%0d", i), 32'(bus.rsp_valid), 32'd0);
        end
        checkOutput("post_reset_op_count", 32'(op_count), 32'd0);
        @(posedge clk); #2;

        // Both requesters valid: grants alternate starting at requester 0
        bus.req0_a = 4'b0001; bus.req0_b = 4'b0001;
        bus.req1_a = 4'b1010; bus.req1_b = 4'b1001;
        expQ.push_back(exp_t'{4'b0010, 1'b0, 1'b0});
        expQ.push_back(exp_t'{4'b1011, 1'b1, 1'b0});
        expQ.push_back(exp_t'{4'b0010, 1'b0, 1'b0});
        expQ.push_back(exp_t'{4'b1011, 1'b1, 1'b0});
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            @(negedge clk);
            if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin
                checkOutput($sformatf("grant_order_%0d", k), 32'(bus.req1_ready), 32'(k % 2));
                k++;
            end
        end
        checkOutput("grant_count", 32'(k), 32'd4);
        @(posedge clk); #2;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
        @(posedge clk); #2;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        checkOutput("op_count_after_alternation", 32'(op_count), 32'd4);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/smadd_arb.md
SMADD_ARB -- requirements
Module: smadd_arb

Interface
REQ-001 Parameter: CNT_W, default 8, width of the completed-operation counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester 0/1 has an operand pair.
REQ-005 req0_ready / req1_ready  output  1 each  requester 0/1 pair accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  4 each  sign-magnitude operands; bit 3 is sign, bits 2:0 are magnitude.
REQ-007 rsp_valid  output  1  result available.
REQ-008 rsp_ready  input  1  consumer accepts result.
REQ-009 rsp_y  output  4  sign-magnitude sum.
REQ-010 rsp_id  output  1  requester that owns rsp_y.
REQ-011 rsp_ovf  output  1  magnitude overflow flag.
REQ-012 op_count  output  CNT_W  count of completed responses.

Function
REQ-013 The block SHALL share one 4-bit sign-magnitude adder between two requesters using a three-state FSM: IDLE, CALC, RESP.
REQ-014 IDLE: when any reqN_valid=1, the block SHALL grant one requester, pulse its reqN_ready for exactly that cycle, latch a, b and the id, and go to CALC; otherwise it SHALL stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: a 1-bit priority pointer favours the requester not granted most recently, and the pointer resets to requester 0.
REQ-016 With a single valid requester, that requester SHALL be granted regardless of the pointer.
REQ-017 CALC: the block SHALL register the adder result, overflow flag and id into the response registers, then go to RESP. rsp_valid SHALL rise 2 cycles after the acceptance edge.
REQ-018 RESP: rsp_valid=1 and all rsp_* outputs SHALL hold stable until rsp_ready=1.
REQ-019 On the rsp_ready edge in RESP, the block SHALL increment op_count (wrapping at 2^CNT_W) and return to IDLE; new grants begin the following cycle.
REQ-020 Minimum spacing between accepts SHALL therefore be 3 cycles.
REQ-021 reqN_ready SHALL be 0 in CALC and RESP.
REQ-022 Overflow SHALL be detected when the operand signs are equal and the 4-bit sum of the magnitudes exceeds 7.
REQ-023 On overflow, rsp_y SHALL saturate to {sign, 111} and rsp_ovf SHALL be 1; otherwise rsp_ovf SHALL be 0.
REQ-024 Negative zero (1000) SHALL never be output; a zero magnitude result SHALL be reported as 0000.
REQ-025 Operands of 1000 SHALL be treated as zero.
REQ-026 Changes on reqN_* inputs after acceptance SHALL not affect the in-flight result.

Reset
REQ-027 While reset=1, the block SHALL asynchronously force: FSM=IDLE, pointer=0, rsp_valid=0, rsp_y=0000, rsp_id=0, rsp_ovf=0, op_count=0, req0_ready=req1_ready=0.
REQ-028 Reset asserted in CALC or RESP SHALL discard the in-flight operation; no response is delivered and op_count is not incremented.
REQ-029 The first grant after reset SHALL be evaluated on the first rising clk edge with reset=0.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, CALC, RESP) and the constants SM_W=4 and MAG_W=3.
REQ-031 The arithmetic SHALL be one instance of the existing smadd sub-module.
REQ-032 Overflow detection, zero normalisation and saturation SHALL be implemented in smadd_arb around that instance.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- req0 a=0011, b=1101, rsp_ready=1 -> rsp_y=1010, rsp_ovf=0, rsp_id=0, rsp_valid 2 cycles after accept, op_count=1.
- req1 a=0101, b=0100 -> rsp_y=0111, rsp_ovf=1; a=1110, b=1011 -> rsp_y=1111, rsp_ovf=1.
- req0 a=1011, b=0011 -> rsp_y=0000, never 1000; a=1000, b=1000 -> rsp_y=0000.
- Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 and rsp_id follows the same order.
- rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_y stable, no reqN_ready, op_count unchanged until the accept edge.
- reset pulsed while in CALC -> rsp_valid stays 0, op_count=0, next grant goes to requester 0.
